// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit accumulator microprocessor.
//   DW, AW       : data width and RAM address width
//   asel_e       : accumulator source select encodings
//   OP_*         : opcode field values, shared with the control unit
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DW = 8;
    localparam int AW = 5;

    // Accumulator source select, matches the 2-bit Asel strobe
    typedef enum logic [1:0] {
        ASEL_ALU  = 2'b00,
        ASEL_IN   = 2'b01,
        ASEL_MEM  = 2'b10,
        ASEL_ZERO = 2'b11
    } asel_e;

    // Opcode field IR[7:5]
    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_INPUT = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

endpackage

// File: rtl/ram32x8.sv
// ---------------------------------------------------------------------------
// ram32x8
// 32 x 8 single-port RAM with a registered read output.
//   clk      : rising-edge clock
//   rst_n    : async active-low reset, clears only the read register
//   wr_en    : write enable
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address, sampled every rising edge
//   rd_data  : registered read data (old contents on read-during-write)
// ---------------------------------------------------------------------------
module ram32x8
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    // The array has no reset so program contents survive a CPU reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of the array gives read-before-write behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/datapath.sv
// ---------------------------------------------------------------------------
// datapath
// PC, IR, accumulator, add/subtract unit and program RAM of the
// accumulator CPU, driven by decoded control strobes.
//   Clock, Reset (async active-low)
//   IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub : control strobes
//   Input                        : external input bus
//   ProgWr, ProgAddr, ProgData   : program-load write port (priority write)
//   IR                           : opcode IR[7:5] to the control unit
//   Aeq0, Apos                   : accumulator status flags
//   Output, PCout                : current A and PC
// ---------------------------------------------------------------------------
module datapath
    import cpu_pkg::*;
(
    input  logic          Clock,
    input  logic          Reset,
    input  logic          IRload,
    input  logic          JMPmux,
    input  logic          PCload,
    input  logic          Meminst,
    input  logic          MemWr,
    input  logic [1:0]    Asel,
    input  logic          Aload,
    input  logic          Sub,
    input  logic [DW-1:0] Input,
    input  logic          ProgWr,
    input  logic [AW-1:0] ProgAddr,
    input  logic [DW-1:0] ProgData,
    output logic [2:0]    IR,
    output logic          Aeq0,
    output logic          Apos,
    output logic [DW-1:0] Output,
    output logic [AW-1:0] PCout
);

    logic [AW-1:0] pc_q;
    logic [DW-1:0] instr_q;
    logic [DW-1:0] acc_q;
    logic [DW-1:0] mem_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] acc_next;
    logic [AW-1:0] pc_next;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          acc_zero;

    assign mem_addr = Meminst ? instr_q[AW-1:0] : pc_q;

    // Program loading wins the single write port; a colliding MemWr is lost.
    assign wr_en   = ProgWr | MemWr;
    assign wr_addr = ProgWr ? ProgAddr : mem_addr;
    assign wr_data = ProgWr ? ProgData : acc_q;

    ram32x8 u_ram (
        .clk     (Clock),
        .rst_n   (Reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (mem_addr),
        .rd_data (mem_data)
    );

    assign alu_result = Sub ? (acc_q - mem_data) : (acc_q + mem_data);
    assign pc_next    = JMPmux ? instr_q[AW-1:0] : pc_q + 1'b1;

    always_comb begin
        acc_next = '0;
        case (asel_e'(Asel))
            ASEL_ALU:  acc_next = alu_result;
            ASEL_IN:   acc_next = Input;
            ASEL_MEM:  acc_next = mem_data;
            ASEL_ZERO: acc_next = '0;
            default:   acc_next = '0;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc_q    <= '0;
            instr_q <= '0;
            acc_q   <= '0;
        end else begin
            if (PCload) begin
                pc_q <= pc_next;
            end
            if (IRload) begin
                instr_q <= mem_data;
            end
            if (Aload) begin
                acc_q <= acc_next;
            end
        end
    end

    assign acc_zero = (acc_q == '0);
    assign Aeq0     = acc_zero;
    assign Apos     = ~acc_q[DW-1] & ~acc_zero;
    assign IR       = instr_q[DW-1:DW-3];
    assign Output   = acc_q;
    assign PCout    = pc_q;

endmodule

// File: tb/tb_datapath.sv
// ---------------------------------------------------------------------------
// tb_datapath
// Directed testbench for datapath with a cycle-level reference model.
// ---------------------------------------------------------------------------
module tb_datapath;
    import cpu_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       IRload = 1'b0;
    logic       JMPmux = 1'b0;
    logic       PCload = 1'b0;
    logic       Meminst = 1'b0;
    logic       MemWr = 1'b0;
    logic [1:0] Asel = 2'b00;
    logic       Aload = 1'b0;
    logic       Sub = 1'b0;
    logic [7:0] Input = 8'h00;
    logic       ProgWr = 1'b0;
    logic [4:0] ProgAddr = 5'd0;
    logic [7:0] ProgData = 8'h00;
    logic [2:0] IR;
    logic       Aeq0;
    logic       Apos;
    logic [7:0] Output;
    logic [4:0] PCout;

    int errors = 0;
    int checks = 0;

    // Reference model state as plain integers
    int mPc = 0;
    int mIr = 0;
    int mA = 0;
    int mMd = 0;
    int mMem [32];

    datapath dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .IRload   (IRload),
        .JMPmux   (JMPmux),
        .PCload   (PCload),
        .Meminst  (Meminst),
        .MemWr    (MemWr),
        .Asel     (Asel),
        .Aload    (Aload),
        .Sub      (Sub),
        .Input    (Input),
        .ProgWr   (ProgWr),
        .ProgAddr (ProgAddr),
        .ProgData (ProgData),
        .IR       (IR),
        .Aeq0     (Aeq0),
        .Apos     (Apos),
        .Output   (Output),
        .PCout    (PCout)
    );

    always #5 Clock = ~Clock;

    function automatic int modelAddr();
        return Meminst ? (mIr % 32) : mPc;
    endfunction

    // Register-level behaviour of the model, updated from the rules of each strobe
    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            mPc <= 0;
            mIr <= 0;
            mA  <= 0;
            mMd <= 0;
        end else begin
            mMd <= mMem[modelAddr()];
            if (IRload) mIr <= mMd;
            if (PCload) mPc <= JMPmux ? (mIr % 32) : ((mPc + 1) % 32);
            if (Aload) begin
                case (Asel)
                    2'b00:   mA <= Sub ? ((mA - mMd + 256) % 256) : ((mA + mMd) % 256);
                    2'b01:   mA <= int'(Input);
                    2'b10:   mA <= mMd;
                    default: mA <= 0;
                endcase
            end
        end
    end

    // Model RAM: not touched by reset, program port has priority
    always @(posedge Clock) begin
        if (ProgWr) mMem[ProgAddr] <= int'(ProgData);
        else if (MemWr) mMem[modelAddr()] <= mA;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Continuous comparison against the model one time unit after every edge
    always @(posedge Clock) begin
        #1;
        checkOutput("model.Output", int'(Output), mA);
        checkOutput("model.PCout", int'(PCout), mPc);
        checkOutput("model.IR", int'(IR), mIr / 32);
        checkOutput("model.Aeq0", int'(Aeq0), (mA == 0) ? 1 : 0);
        checkOutput("model.Apos", int'(Apos), (mA >= 1 && mA <= 127) ? 1 : 0);
    end

    task automatic applyStimulus(
        input logic       irl,
        input logic       pcl,
        input logic       jmp,
        input logic       mi,
        input logic       mw,
        input logic       al,
        input logic [1:0] as,
        input logic       sb,
        input logic [7:0] inp,
        input logic       pw,
        input logic [4:0] pa,
        input logic [7:0] pd
    );
        @(negedge Clock);
        IRload   = irl;
        PCload   = pcl;
        JMPmux   = jmp;
        Meminst  = mi;
        MemWr    = mw;
        Aload    = al;
        Asel     = as;
        Sub      = sb;
        Input    = inp;
        ProgWr   = pw;
        ProgAddr = pa;
        ProgData = pd;
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input logic mi);
        applyStimulus(0, 0, 0, mi, 0, 0, 2'b00, 0, 8'h00, 0, 5'd0, 8'h00);
    endtask

    task automatic progWrite(input logic [4:0] pa, input logic [7:0] pd);
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0, 8'h00, 1, pa, pd);
    endtask

    task automatic pcInc();
        applyStimulus(0, 1, 0, 0, 0, 0, 2'b00, 0, 8'h00, 0, 5'd0, 8'h00);
    endtask

    task automatic clearControls();
        IRload  = 0; PCload = 0; JMPmux = 0; Meminst = 0; MemWr = 0;
        Aload   = 0; Asel = 2'b00; Sub = 0; Input = 8'h00; ProgWr = 0;
    endtask

    initial begin
        // Load program words while the CPU is held in reset
        progWrite(5'd20, 8'h05);
        progWrite(5'd21, 8'h07);
        progWrite(5'd9,  8'h99);
        progWrite(5'd0,  8'hB4);
        progWrite(5'd5,  8'h5A);
        checkOutput("reset.Output", int'(Output), 0);
        checkOutput("reset.PCout", int'(PCout), 0);
        checkOutput("reset.IR", int'(IR), 0);
        checkOutput("reset.Aeq0", int'(Aeq0), 1);
        checkOutput("reset.Apos", int'(Apos), 0);
        @(negedge Clock);
        Reset = 1'b1;

        // Fetch jz 20 from address 0, then take the jump
        idle(0);
        applyStimulus(1, 1, 0, 0, 0, 0, 2'b00, 0, 8'h00, 0, 5'd0, 8'h00);
        checkOutput("fetch.IR", int'(IR), 5);
        checkOutput("fetch.PC", int'(PCout), 1);
        applyStimulus(0, 1, 1, 0, 0, 0, 2'b00, 0, 8'h00, 0, 5'd0, 8'h00);
        checkOutput("jump.PC", int'(PCout), 20);

        // load 20, add 21, sub 20
        idle(0);
        applyStimulus(0, 1, 0, 0, 0, 1, ASEL_MEM, 0, 8'h00, 0, 5'd0, 8'h00);
        checkOutput("load.A", int'(Output), 8'h05);
        idle(0);
        applyStimulus(0, 0, 0, 0, 0, 1, ASEL_ALU, 0, 8'h00, 0, 5'd0, 8'h00);
        checkOutput("add.A", int'(Output), 8'h0C);
        idle(1);
        applyStimulus(0, 0, 0, 1, 0, 1, ASEL_ALU, 1, 8'h00, 0, 5'd0, 8'h00);
        checkOutput("sub.A", int'(Output), 8'h07);

        // Subtract wrap 2 - 3, then + 1 back to zero
        applyStimulus(0, 1, 0, 0, 0, 1, ASEL_IN, 0, 8'h02, 1, 5'd22, 8'h03);
        progWrite(5'd23, 8'h01);
        applyStimulus(0, 1, 0, 0, 0, 1, ASEL_ALU, 1, 8'h00, 0, 5'd0, 8'h00);
        checkOutput("wrap.A", int'(Output), 8'hFF);
        checkOutput("wrap.Apos", int'(Apos), 0);
        checkOutput("wrap.Aeq0", int'(Aeq0), 0);
        idle(0);
        applyStimulus(0, 0, 0, 0, 0, 1, ASEL_ALU, 0, 8'h00, 0, 5'd0, 8'h00);
        checkOutput("wrapadd.A", int'(Output), 8'h00);
        checkOutput("wrapadd.Aeq0", int'(Aeq0), 1);

        // Store with simultaneous A clear, read-during-write returns old data
        applyStimulus(0, 1, 0, 0, 0, 1, ASEL_IN, 0, 8'h3C, 1, 5'd24, 8'h29);
        idle(0);
        applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 0, 8'h00, 0, 5'd0, 8'h00);
        checkOutput("store.IR", int'(IR), 1);
        applyStimulus(0, 0, 0, 1, 1, 1, ASEL_ZERO, 0, 8'h00, 0, 5'd0, 8'h00);
        applyStimulus(0, 0, 0, 1, 0, 1, ASEL_MEM, 0, 8'h00, 0, 5'd0, 8'h00);
        checkOutput("rdw.oldMD", int'(Output), 8'h99);
        applyStimulus(0, 0, 0, 1, 0, 1, ASEL_MEM, 0, 8'h00, 0, 5'd0, 8'h00);
        checkOutput("store.newMD", int'(Output), 8'h3C);

        // Jump to 31, then increment wraps to 0
        applyStimulus(0, 1, 0, 0, 0, 0, 2'b00, 0, 8'h00, 1, 5'd25, 8'hFF);
        idle(0);
        applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 0, 8'h00, 0, 5'd0, 8'h00);
        checkOutput("halt.IR", int'(IR), 7);
        applyStimulus(0, 1, 1, 0, 0, 0, 2'b00, 0, 8'h00, 0, 5'd0, 8'h00);
        checkOutput("jump31.PC", int'(PCout), 31);
        pcInc();
        checkOutput("pcwrap.PC", int'(PCout), 0);

        // ProgWr beats a same-edge MemWr to the same address
        applyStimulus(0, 1, 0, 0, 0, 1, ASEL_IN, 0, 8'h11, 0, 5'd0, 8'h00);
        pcInc();
        pcInc();
        applyStimulus(0, 0, 0, 0, 1, 0, 2'b00, 0, 8'h00, 1, 5'd3, 8'hAA);
        idle(0);
        applyStimulus(0, 0, 0, 0, 0, 1, ASEL_MEM, 0, 8'h00, 0, 5'd0, 8'h00);
        checkOutput("progprio.A", int'(Output), 8'hAA);
        applyStimulus(0, 0, 0, 0, 0, 1, ASEL_IN, 0, 8'h80, 0, 5'd0, 8'h00);
        checkOutput("input.A", int'(Output), 8'h80);
        checkOutput("input.Apos", int'(Apos), 0);
        checkOutput("input.Aeq0", int'(Aeq0), 0);

        // Mid-cycle reset with A=0x55, PC=7
        applyStimulus(0, 1, 0, 0, 0, 1, ASEL_IN, 0, 8'h55, 0, 5'd0, 8'h00);
        pcInc();
        pcInc();
        pcInc();
        checkOutput("prereset.A", int'(Output), 8'h55);
        checkOutput("prereset.PC", int'(PCout), 7);
        #3;
        clearControls();
        Reset = 1'b0;
        #1;
        checkOutput("midreset.Output", int'(Output), 0);
        checkOutput("midreset.PCout", int'(PCout), 0);
        checkOutput("midreset.IR", int'(IR), 0);
        checkOutput("midreset.Aeq0", int'(Aeq0), 1);
        checkOutput("midreset.Apos", int'(Apos), 0);
        @(negedge Clock);
        Reset = 1'b1;

        // RAM survives reset
        for (int i = 0; i < 5; i++) pcInc();
        idle(0);
        applyStimulus(0, 0, 0, 0, 0, 1, ASEL_MEM, 0, 8'h00, 0, 5'd0, 8'h00);
        checkOutput("ramkeep.A", int'(Output), 8'h5A);

        idle(0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/datapath.md
# datapath

Datapath for the 8-bit accumulator microprocessor. It sits directly downstream of the control unit. It holds the PC, the IR, the accumulator A, a 32×8 synchronous RAM and the add/subtract unit, and each cycle it acts on the decoded control strobes. It feeds back to the control unit the opcode field IR[7:5] and the status flags Aeq0 and Apos.

## Interface
- DW, 8, data/accumulator/instruction width
- AW, 5, address width (memory depth 2^AW = 32)

- Clock  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-low
- IRload  in  1  load IR from RAM read data
- JMPmux  in  1  PC next-value select: 0 = PC+1, 1 = IR[4:0]
- PCload  in  1  PC load enable
- Meminst  in  1  RAM address select: 0 = PC, 1 = IR[4:0]
- MemWr  in  1  write A into RAM at the selected address
- Asel  in  2  A source select: 00 ALU, 01 Input, 10 RAM data, 11 constant 0
- Aload  in  1  A load enable
- Sub  in  1  ALU mode: 0 = A+M, 1 = A−M
- Input  in  DW  external input bus
- ProgWr  in  1  program-load write strobe
- ProgAddr  in  AW  program-load address
- ProgData  in  DW  program-load data
- IR  out  3  IR[7:5] opcode to the control unit
- Aeq0  out  1  A == 0
- Apos  out  1  A strictly positive (A[7]==0 and A!=0)
- Output  out  DW  current A
- PCout  out  AW  current PC

## Operation
- RAM address = Meminst ? IR[4:0] : PC.
- RAM read is synchronous: the registered data output MD gets mem[address] on every rising edge.
- Read-during-write to the same address returns the old data.
- Write on the rising edge:
  - When ProgWr=1: mem[ProgAddr] <= ProgData.
  - Otherwise, when MemWr=1: mem[address] <= A.
  - ProgWr has priority. A MemWr that coincides with ProgWr is dropped.
- IRload=1: IR <= MD.
- PCload=1: PC <= JMPmux ? IR[4:0] : PC+1. The PC wraps from 31 to 0.
- Aload=1: A <= the mux selected by Asel.
- ALU result: (A + MD) or (A − MD), modulo 2^8, two's complement. No carry or overflow output.
- Aeq0 and Apos are combinational from A.
- Resulting behaviour per control-unit state:
  - Fetch: IR captures the instruction word read at PC.
  - Decode: presents the operand address.
  - load/add/sub: consume MD for operand IR[4:0] in the next state.
  - Store: writes A.
  - jz/jpos: jump when the control unit gates PCload.
- All control inputs are independent. Any combination is legal and acts in parallel on the same edge.

## Timing
- Reset asserted, at any time including mid-instruction: PC, IR, A and MD go to 0 immediately.
  - Outputs: IR=000, Aeq0=1, Apos=0, Output=0, PCout=0.
  - RAM contents are not altered by reset.
- Latency:
  - Address to MD: 1 cycle.
  - Control strobe to register update: the same edge.
  - Flags: valid the same cycle A changes.
- Fetch sequence (start→fetch→decode→exec) puts the new opcode on IR one cycle after the fetch edge.
- ProgWr is intended to be used while the control unit is held in reset. ProgWr during normal operation is still legal and takes priority.
- Simultaneous IRload and PCload (fetch): IR takes MD at the old PC, and PC increments on the same edge.
- Simultaneous Aload and MemWr: RAM stores the old A.

## Structure
- Shared package `cpu_pkg`:
  - DW and AW.
  - Asel encodings: ASEL_ALU, ASEL_IN, ASEL_MEM, ASEL_ZERO.
  - Opcode constants: OP_LOAD=000 … OP_HALT=111, shared with the control unit.
- One sub-module, `ram32x8`: synchronous read, single write port, read-before-write, no reset on the array.
- PC, IR, A, the ALU and the muxes live in `datapath`.

## Test plan
- Reset check:
  - Stimulus: assert Reset low mid-cycle with A=0x55 and PC=7.
  - Required: A=0, PC=0, IR=000, Aeq0=1, Apos=0 before the next edge; a RAM word written before reset reads back unchanged.
- Load/add/sub:
  - Stimulus: program mem[20]=0x05 and mem[21]=0x07, then drive the control sequence load 20, add 21, sub 20.
  - Required: A=0x05, then 0x0C, then 0x07.
- Subtract wrap:
  - Stimulus: A=0x02, MD=0x03, Sub=1.
  - Required: A=0xFF, Apos=0, Aeq0=0.
  - Then A + 0x01 gives A=0x00 and Aeq0=1.
- Store and read-during-write:
  - Stimulus: A=0x3C with Meminst=1, IR[4:0]=9, MemWr=1.
  - Required: MD shows the old mem[9] that cycle, and 0x3C on the following read.
- Jump and PC wrap:
  - Stimulus: IR=0xB4 (jz 20) with JMPmux=1, PCload=1.
  - Required: PC=20.
  - Also: PC=31 with PCload=1 and JMPmux=0 gives PC=0.
- ProgWr priority and input path:
  - Stimulus: ProgWr to address 3 with data 0xAA, with MemWr and A=0x11 on the same edge.
  - Required: mem[3]=0xAA.
  - Asel=01 with Input=0x80 and Aload=1 gives A=0x80 and Apos=0.
